// File: rtl/dram_refresh_exec.sv
// dram_refresh_exec: takes the SDRAM command bus on a refresh request, issues
// PRECHARGE ALL followed by REF_COUNT AUTO REFRESH commands with tRP/tRFC
// spacing, then pulses refresh_ack for one cycle.
module dram_refresh_exec #(
  parameter int unsigned T_RP      = 3,
  parameter int unsigned T_RFC     = 9,
  parameter int unsigned REF_COUNT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic refresh_req,
  input  logic user_busy,
  output logic refresh_active,
  output logic refresh_ack,
  output logic dram_cs_n,
  output logic dram_ras_n,
  output logic dram_cas_n,
  output logic dram_we_n,
  output logic dram_a10
);

  localparam int unsigned T_MAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);
  localparam int unsigned REF_W = $clog2(REF_COUNT + 1);

  localparam logic [CNT_W-1:0] TRP_LOAD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] TRFC_LOAD = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REF_COUNT);
  localparam logic [REF_W-1:0] REF_ONE   = REF_W'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_PRE  = 3'd2;
  localparam logic [2:0] S_TRP  = 3'd3;
  localparam logic [2:0] S_REF  = 3'd4;
  localparam logic [2:0] S_TRFC = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // Command pin image {cs_n, ras_n, cas_n, we_n, a10}
  localparam logic [4:0] CMD_DESEL = 5'b11110;
  localparam logic [4:0] CMD_NOP   = 5'b01110;
  localparam logic [4:0] CMD_PRE   = 5'b00101;
  localparam logic [4:0] CMD_REF   = 5'b00010;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic [REF_W-1:0] ref_cnt_inc;
  logic [4:0]       cmd_q, cmd_d;
  logic             active_q, active_d;
  logic             ack_q, ack_d;

  assign ref_cnt_inc = ref_cnt_q + REF_ONE;

  // Next-state, counters, and output decode of the state being entered
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_cnt_d = ref_cnt_q;
    cmd_d     = CMD_NOP;
    active_d  = 1'b1;
    ack_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ref_cnt_d = '0;
        if (refresh_req && enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!enable)         state_d = S_IDLE;
        else if (!user_busy) state_d = S_PRE;
      end
      S_PRE: begin
        if (T_RP == 1) begin
          state_d = S_REF;
        end else begin
          cnt_d   = TRP_LOAD;
          state_d = S_TRP;
        end
      end
      S_TRP: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_REF;
      end
      S_REF: begin
        ref_cnt_d = ref_cnt_inc;
        if (T_RFC == 1) begin
          state_d = (ref_cnt_inc < REF_LAST) ? S_REF : S_DONE;
        end else begin
          cnt_d   = TRFC_LOAD;
          state_d = S_TRFC;
        end
      end
      S_TRFC: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = (ref_cnt_q < REF_LAST) ? S_REF : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_IDLE: begin
        cmd_d    = CMD_DESEL;
        active_d = 1'b0;
      end
      S_WAIT:  cmd_d = CMD_DESEL;
      S_PRE:   cmd_d = CMD_PRE;
      S_REF:   cmd_d = CMD_REF;
      S_DONE:  ack_d = 1'b1;
      default: cmd_d = CMD_NOP;
    endcase
  end

  // State, counters and registered pin image
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ref_cnt_q <= '0;
      cmd_q     <= CMD_DESEL;
      active_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_cnt_q <= ref_cnt_d;
      cmd_q     <= cmd_d;
      active_q  <= active_d;
      ack_q     <= ack_d;
    end
  end

  assign {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_a10} = cmd_q;
  assign refresh_active = active_q;
  assign refresh_ack    = ack_q;

endmodule
